// File: rtl/tile_operand_loader.sv
// Serial fp16 word stream to registered 4x4 A/B operand tiles with a valid/ready handover.
// Optional shadow buffer for back-to-back pairs: define TILE_PINGPONG_EN.
module tile_operand_loader #(
    parameter int unsigned ELEM_W     = 16,
    parameter int unsigned TILE_ELEMS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W-1:0]            in_data,
    input  logic                         in_last,
    output logic [ELEM_W*TILE_ELEMS-1:0] a_tile,
    output logic [ELEM_W*TILE_ELEMS-1:0] b_tile,
    output logic                         tile_valid,
    input  logic                         tile_ready,
    output logic                         err_len
);

    localparam int unsigned CNT_W = $clog2(TILE_ELEMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILE_ELEMS - 1);

    // HOLD doubles as "shadow complete" for the shadow fill phase.
    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ELEM_W-1:0]  a_q [TILE_ELEMS];
    logic [ELEM_W-1:0]  a_d [TILE_ELEMS];
    logic [ELEM_W-1:0]  b_q [TILE_ELEMS];
    logic [ELEM_W-1:0]  b_d [TILE_ELEMS];
    logic               in_ready_q, in_ready_d;
    logic               tile_valid_q, tile_valid_d;
    logic               err_q, err_d;

`ifdef TILE_PINGPONG_EN
    state_t             sph_q, sph_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [ELEM_W-1:0]  sa_q [TILE_ELEMS];
    logic [ELEM_W-1:0]  sa_d [TILE_ELEMS];
    logic [ELEM_W-1:0]  sb_q [TILE_ELEMS];
    logic [ELEM_W-1:0]  sb_d [TILE_ELEMS];
`endif

    logic               accept;
    logic               consume;
    state_t             cur_ph, ing_ph;
    logic [CNT_W-1:0]   cur_cnt, ing_cnt;
    logic               wr_a, wr_b, ing_err;

    // Word sequencing and framing, shared by the front and the shadow buffer.
    always_comb begin
        accept  = in_valid && in_ready_q;
        consume = tile_valid_q && tile_ready;
`ifdef TILE_PINGPONG_EN
        cur_ph  = (state_q == HOLD) ? sph_q  : state_q;
        cur_cnt = (state_q == HOLD) ? scnt_q : count_q;
`else
        cur_ph  = state_q;
        cur_cnt = count_q;
`endif
        ing_ph  = cur_ph;
        ing_cnt = cur_cnt;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        ing_err = 1'b0;
        if (accept) begin
            case (cur_ph)
                FILL_A: begin
                    if (in_last) begin
                        ing_err = 1'b1;
                        ing_ph  = FILL_A;
                        ing_cnt = '0;
                    end else begin
                        wr_a    = 1'b1;
                        ing_cnt = CNT_W'(cur_cnt + CNT_W'(1));
                        if (cur_cnt == LAST_IDX) begin
                            ing_ph = FILL_B;
                        end
                    end
                end
                FILL_B: begin
                    if (cur_cnt == LAST_IDX) begin
                        wr_b    = 1'b1;
                        ing_ph  = HOLD;
                        ing_cnt = '0;
                        ing_err = !in_last;
                    end else if (in_last) begin
                        ing_err = 1'b1;
                        ing_ph  = FILL_A;
                        ing_cnt = '0;
                    end else begin
                        wr_b    = 1'b1;
                        ing_cnt = CNT_W'(cur_cnt + CNT_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = ing_err;
`ifdef TILE_PINGPONG_EN
        sph_d   = sph_q;
        scnt_d  = scnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        if (state_q != HOLD) begin
            state_d = ing_ph;
            count_d = ing_cnt;
            if (wr_a) begin
                a_d[cur_cnt] = in_data;
            end
            if (wr_b) begin
                b_d[cur_cnt] = in_data;
            end
        end else begin
`ifdef TILE_PINGPONG_EN
            sph_d  = ing_ph;
            scnt_d = ing_cnt;
            if (wr_a) begin
                sa_d[cur_cnt] = in_data;
            end
            if (wr_b) begin
                sb_d[cur_cnt] = in_data;
            end
            // Handover: a partial shadow keeps filling as the front buffer.
            if (consume) begin
                a_d     = sa_d;
                b_d     = sb_d;
                state_d = sph_d;
                count_d = (sph_d == HOLD) ? '0 : scnt_d;
                sph_d   = FILL_A;
                scnt_d  = '0;
            end
`else
            if (consume) begin
                state_d = FILL_A;
                count_d = '0;
            end
`endif
        end
`ifdef TILE_PINGPONG_EN
        in_ready_d = (state_d != HOLD) || (sph_d != HOLD);
`else
        in_ready_d = (state_d != HOLD);
`endif
        tile_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL_A;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            tile_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int k = 0; k < int'(TILE_ELEMS); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            tile_valid_q <= tile_valid_d;
            err_q        <= err_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

`ifdef TILE_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sph_q  <= FILL_A;
            scnt_q <= '0;
            for (int k = 0; k < int'(TILE_ELEMS); k++) begin
                sa_q[k] <= '0;
                sb_q[k] <= '0;
            end
        end else begin
            sph_q  <= sph_d;
            scnt_q <= scnt_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
        end
    end
`endif

    for (genvar k = 0; k < int'(TILE_ELEMS); k++) begin : g_flat
        assign a_tile[k*ELEM_W +: ELEM_W] = a_q[k];
        assign b_tile[k*ELEM_W +: ELEM_W] = b_q[k];
    end

    assign in_ready   = in_ready_q;
    assign tile_valid = tile_valid_q;
    assign err_len    = err_q;

endmodule

// File: tb/tb_tile_operand_loader.sv
// Scoreboard bench for tile_operand_loader: expected pairs queued as words are driven.
module tb_tile_operand_loader;

    localparam int unsigned EW = 16;
    localparam int unsigned TE = 16;
    localparam int unsigned FW = EW * TE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [FW-1:0] a_tile;
    logic [FW-1:0] b_tile;
    logic          tile_valid;
    logic          tile_ready = 1'b0;
    logic          err_len;

    int total = 0;
    int bad   = 0;

    logic [2*FW-1:0] sb_q [$];
    logic [2*FW-1:0] exp_pair;

    always #5 clk = ~clk;

    tile_operand_loader #(.ELEM_W(EW), .TILE_ELEMS(TE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .a_tile     (a_tile),
        .b_tile     (b_tile),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .err_len    (err_len)
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference flags for the single-buffer loader, stepped on each rising edge.
    int m_ph  = 0;
    int m_cnt = 0;
    bit m_tv  = 1'b0;
    bit m_rdy = 1'b0;
    bit m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_tv = 1'b0; m_rdy = 1'b0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_ph == 2) begin
                if (tile_ready) begin
                    m_ph = 0; m_cnt = 0;
                end
            end else if (in_valid && m_rdy) begin
                if (in_last && !(m_ph == 1 && m_cnt == 15)) begin
                    m_err = 1'b1; m_ph = 0; m_cnt = 0;
                end else if (m_cnt == 15) begin
                    m_cnt = 0;
                    if (m_ph == 1) begin
                        m_ph = 2; m_err = !in_last;
                    end else begin
                        m_ph = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            m_tv  = (m_ph == 2);
            m_rdy = (m_ph != 2);
        end
    end

    bit mon_en  = 1'b0;
    bit tv_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
`ifndef TILE_PINGPONG_EN
            logic [2*FW-1:0] e;
            check("tile_valid", FW'(tile_valid), FW'(m_tv));
            check("in_ready", FW'(in_ready), FW'(m_rdy));
            check("err_len", FW'(err_len), FW'(m_err));
            if (tile_valid && !tv_prev) begin
                check("sb_nonempty", FW'(sb_q.size() != 0), FW'(1'b1));
                e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
                check("sb_a_tile", a_tile, e[FW-1:0]);
                check("sb_b_tile", b_tile, e[2*FW-1:FW]);
            end
`endif
            tv_prev = tile_valid;
        end
    end

    // Drive one word and return on the falling edge after it is accepted.
    task automatic send_word(input logic [EW-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", FW'(n), FW'(0));
        @(negedge clk);
    endtask

    task automatic send_stream(input logic [EW-1:0] base, input int n, input int last_at, input bit push);
        logic [2*FW-1:0] e = '0;
        for (int k = 0; k < 32; k++) e[k*EW +: EW] = EW'(base + EW'(k));
        for (int k = 0; k < n; k++) begin
            if (push && k == n - 1) begin
                sb_q.push_back(e);
                exp_pair = e;
            end
            send_word(EW'(base + EW'(k)), k == last_at);
        end
    endtask

    task automatic consume_pair();
        in_valid   = 1'b0;
        tile_ready = 1'b1;
        @(negedge clk);
        tile_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [2*FW-1:0] e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst_a_tile", a_tile, '0);
        check("rst_b_tile", b_tile, '0);
        check("rst_in_ready", FW'(in_ready), FW'(0));
        check("rst_tile_valid", FW'(tile_valid), FW'(0));
        rst = 1'b0;
        @(negedge clk);

`ifndef TILE_PINGPONG_EN
        // Basic pair with in_last on word 31.
        send_stream(16'h3C00, 32, 31, 1'b1);
        check("t1_tile_valid", FW'(tile_valid), FW'(1));
        check("t1_a5", FW'(a_tile[5*EW +: EW]), FW'(16'h3C05));
        check("t1_b15", FW'(b_tile[15*EW +: EW]), FW'(16'h3C1F));
        check("t1_err", FW'(err_len), FW'(0));

        // Hold with words offered: nothing accepted, tiles stable.
        in_data = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_in_ready", FW'(in_ready), FW'(0));
        end
        check("hold_a_tile", a_tile, exp_pair[FW-1:0]);
        check("hold_b_tile", b_tile, exp_pair[2*FW-1:FW]);
        consume_pair();
        check("rel_tile_valid", FW'(tile_valid), FW'(0));
        check("rel_in_ready", FW'(in_ready), FW'(1));

        // tile_ready with no pair is ignored.
        tile_ready = 1'b1;
        repeat (3) @(negedge clk);
        tile_ready = 1'b0;

        // Early in_last on word 9, then a clean pair.
        send_stream(16'h4000, 10, 9, 1'b0);
        check("early_err", FW'(err_len), FW'(1));
        check("early_tv", FW'(tile_valid), FW'(0));
        send_stream(16'h4400, 32, 31, 1'b1);
        check("after_err_a0", FW'(a_tile[0 +: EW]), FW'(16'h4400));
        consume_pair();

        // Missing in_last: pair still presented, err pulses.
        send_stream(16'h5000, 32, -1, 1'b1);
        check("nolast_tv", FW'(tile_valid), FW'(1));
        check("nolast_err", FW'(err_len), FW'(1));
        check("nolast_b0", FW'(b_tile[0 +: EW]), FW'(16'h5010));
        consume_pair();

        // Reset in the middle of a fill.
        send_stream(16'h6000, 20, -1, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_tv", FW'(tile_valid), FW'(0));
        check("mid_rst_a", a_tile, '0);
        check("mid_rst_b", b_tile, '0);
        rst = 1'b0;
        @(negedge clk);
        send_stream(16'h7000, 32, 31, 1'b1);
        check("fresh_a0", FW'(a_tile[0 +: EW]), FW'(16'h7000));
        check("fresh_b15", FW'(b_tile[15*EW +: EW]), FW'(16'h701F));
        consume_pair();
        repeat (3) @(negedge clk);
`else
        // Two pairs streamed while the first is held; second lands in the shadow.
        send_stream(16'h8000, 32, 31, 1'b1);
        send_stream(16'h8100, 32, 31, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("pp_tv_first", FW'(tile_valid), FW'(1));
        check("pp_full_rdy", FW'(in_ready), FW'(0));
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        check("pp_a_first", a_tile, e[FW-1:0]);
        check("pp_b_first", b_tile, e[2*FW-1:FW]);
        consume_pair();
        check("pp_tv_handover", FW'(tile_valid), FW'(1));
        check("pp_a0_second", FW'(a_tile[0 +: EW]), FW'(16'h8100));
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        check("pp_a_second", a_tile, e[FW-1:0]);
        check("pp_b_second", b_tile, e[2*FW-1:FW]);
        check("pp_rdy_after", FW'(in_ready), FW'(1));
        consume_pair();
        check("pp_tv_drop", FW'(tile_valid), FW'(0));
`endif
        check("sb_empty", FW'(sb_q.size()), FW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_operand_loader.md
Name: tile_operand_loader

Overview:
- Upstream feeder for the 4x4 fp16 matrix-multiply stage.
- Accepts a serial stream of fp16 words over a valid/ready handshake and assembles a 16-element A tile, then a 16-element B tile.
- Presents both tiles as stable, registered arrays with a tile_valid/tile_ready handshake until the multiplier side consumes them.

Parameters:
- ELEM_W, 16, element width in bits (fp16).
- TILE_ELEMS, 16, elements per operand tile; fixed 4x4 row-major. Only the value 16 is supported.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  ELEM_W  fp16 element, row-major: A[0..15], then B[0..15].
- in_last  input  1  marks the final (32nd) word of a tile pair.
- a_tile  output  ELEM_W x TILE_ELEMS  A operand array; element k = row k/4, column k%4.
- b_tile  output  ELEM_W x TILE_ELEMS  B operand array; same indexing as a_tile.
- tile_valid  output  1  a_tile/b_tile hold a complete pair.
- tile_ready  input  1  consumer takes the pair this cycle.
- err_len  output  1  one-cycle pulse on a framing error.

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset rst is synchronous and active-high.
  - While rst=1: state=FILL_A, count=0, tile_valid=0, err_len=0, in_ready=0, all a_tile/b_tile elements=0.
  - in_ready may go to 1 on the first cycle after rst deasserts.
- Handshakes:
  - A word is accepted only when in_valid && in_ready.
  - A pair is consumed only when tile_valid && tile_ready.
  - in_data and in_last are ignored when not accepted.
- State machine: FILL_A -> FILL_B -> HOLD -> FILL_A. count is 4 bits.
  - FILL_A: in_ready=1. Each accepted word is written to a_tile[count] and count increments. On the accept at count=15, go to FILL_B with count=0.
  - FILL_B: in_ready=1. Each accepted word is written to b_tile[count]. On the accept at count=15, go to HOLD.
  - HOLD: tile_valid=1, in_ready=0. On tile_ready, go to FILL_A with count=0; tile_valid=0 on the next cycle.
- Latency and throughput:
  - tile_valid rises the cycle after the 32nd word is accepted.
  - Best-case throughput: one pair per 33 cycles.
- Output stability:
  - a_tile/b_tile are registered and unchanged while tile_valid=1.
  - Between tiles, elements not yet rewritten keep their old values.
- Framing:
  - in_last=1 on any accepted word other than the 32nd: pulse err_len the next cycle, discard the partial tile, and return to FILL_A with count=0. tile_valid is not asserted.
  - 32nd word accepted with in_last=0: the tile is still presented normally, and err_len pulses the next cycle.
- tile_ready while tile_valid=0: ignored.
- Reset mid-fill or mid-HOLD: the pair is abandoned and all outputs return to reset values.

Optional Feature:
- Macro: TILE_PINGPONG_EN.
- Defined: a shadow A/B buffer is added.
  - While in HOLD, in_ready stays 1 and incoming words fill the shadow with the same sequencing and framing rules.
  - When the shadow is complete and the front is still held, in_ready=0.
  - On a tile_ready handshake with the shadow complete, the shadow is copied to the front in the same edge and tile_valid stays 1, giving back-to-back pairs.
  - On a tile_ready handshake with the shadow incomplete, tile_valid drops and the front is loaded when the shadow completes.
  - Best-case throughput: one pair per 32 cycles.
  - A framing error in the shadow discards only the shadow.
- Undefined: single buffer, behaviour exactly as in Behaviour.

Test Plan:
- Reset then stream in_data=0x3C00+k for k=0..31 with in_valid=1 continuously and in_last on k=31 -> cycle after k=31 accept: tile_valid=1, a_tile[5]=0x3C05, b_tile[15]=0x3C1F, err_len=0.
- Hold tile_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 throughout, tiles unchanged. Then tile_ready=1 for one cycle -> tile_valid=0 the next cycle, in_ready=1.
- in_last=1 on the 10th word (k=9) -> err_len pulses once, no tile_valid. The following full 32-word stream produces a correct tile.
- 32 words with in_last=0 -> tile_valid=1 and err_len=1 for one cycle.
- Assert rst at word 20 -> next cycle tile_valid=0, a_tile all 0x0000. A fresh 32-word load is accepted from index 0.
- With TILE_PINGPONG_EN defined, two back-to-back 32-word streams and tile_ready=1 -> tile_valid stays high across the handover, and second-pair a_tile[0] equals word 32's data.
